fas_seq_ctrl: RTL and testbench

FAS_SEQ_CTRL -- requirements
Module: fas_seq_ctrl

---
 rtl/fas_seq_ctrl_if.sv | 30 +++
 rtl/fas_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_fas_seq_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fas_seq_ctrl_if.sv
// Signal bundle between the FIR/FFT datapath and the frame sequencing controller.
// The controller side uses the slave modport; the environment drives through master.
interface fas_seq_ctrl_if;
  logic        fir_valid;
  logic [15:0] fir_d;
  logic        buf_wr_en;
  logic [3:0]  buf_wr_addr;
  logic [15:0] buf_wr_data;
  logic        fft_start;
  logic        fft_done;
  logic [3:0]  bin_sel;
  logic [15:0] bin_re;
  logic [15:0] bin_im;
  logic [3:0]  freq;
  logic        done;
  logic [6:0]  frame_cnt;
  logic        overrun;

  modport master (
    output fir_valid, fir_d, fft_done, bin_re, bin_im,
    input  buf_wr_en, buf_wr_addr, buf_wr_data, fft_start, bin_sel, freq, done, frame_cnt,
           overrun
  );

  modport slave (
    input  fir_valid, fir_d, fft_done, bin_re, bin_im,
    output buf_wr_en, buf_wr_addr, buf_wr_data, fft_start, bin_sel, freq, done, frame_cnt,
           overrun
  );
endinterface

// File: rtl/fas_seq_ctrl.sv
// Frame sequencer: fills a 16-entry FFT buffer from the FIR stream, launches the FFT,
// then scans the 16 bins for the largest magnitude and reports its index.
module fas_seq_ctrl #(
  parameter int unsigned FRAME_LIMIT = 64
) (
  input logic           clk,
  input logic           rst,
  fas_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  localparam logic [6:0] Limit = 7'(FRAME_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  wptr_q, wptr_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] max_q, max_d;
  logic [3:0]  best_q, best_d;
  logic [3:0]  freq_q, freq_d;
  logic [6:0]  frame_cnt_q, frame_cnt_d;
  logic        overrun_q, overrun_d;

  logic        halted, frame_end, launch, collide, bin_better;
  logic signed [31:0] re_ext, im_ext, re_sq, im_sq;
  logic [31:0] mag;

  always_comb begin
    halted    = (frame_cnt_q == Limit);
    frame_end = wr_en_q && (wr_addr_q == 4'd15);
    // A same-cycle fft_done frees the FFT in time for this frame.
    launch    = frame_end && (!busy_q || bus.fft_done) && !halted;
    collide   = frame_end && busy_q && !bus.fft_done;

    re_ext = 32'(signed'(bus.bin_re));
    im_ext = 32'(signed'(bus.bin_im));
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
    // Sum peaks at 2^31, which still fits when read back as unsigned.
    mag    = unsigned'(re_sq + im_sq);
    bin_better = (idx_q == 4'd0) || (mag > max_q);
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    start_d     = launch;
    busy_d      = busy_q;
    idx_d       = idx_q;
    max_d       = max_q;
    best_d      = best_q;
    freq_d      = freq_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q || collide;

    if (bus.fir_valid && !halted) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wptr_q;
      wr_data_d = bus.fir_d;
      wptr_d    = wptr_q + 4'd1;
    end

    if (launch) begin
      busy_d = 1'b1;
    end else if (bus.fft_done) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.fft_done) begin
          state_d = StScan;
          idx_d   = 4'd0;
        end
      end
      StScan: begin
        if (bus.fft_done) overrun_d = 1'b1;
        if (bin_better) begin
          max_d  = mag;
          best_d = idx_q;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = StReport;
          freq_d  = bin_better ? idx_q : best_q;
          if (frame_cnt_q < Limit) frame_cnt_d = frame_cnt_q + 7'd1;
        end
      end
      StReport: begin
        if (bus.fft_done) overrun_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wptr_q      <= 4'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 16'd0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      idx_q       <= 4'd0;
      max_q       <= 32'd0;
      best_q      <= 4'd0;
      freq_q      <= 4'd0;
      frame_cnt_q <= 7'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      best_q      <= best_d;
      freq_q      <= freq_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.buf_wr_en   = wr_en_q;
  assign bus.buf_wr_addr = wr_addr_q;
  assign bus.buf_wr_data = wr_data_q;
  assign bus.fft_start   = start_q;
  assign bus.bin_sel     = (state_q == StScan) ? idx_q : 4'd0;
  assign bus.freq        = freq_q;
  assign bus.done        = (state_q == StReport);
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_fas_seq_ctrl.sv
// Bench for fas_seq_ctrl: directed frames plus randomized traffic, checked every cycle
// against an event-timestamp reference model.
module tb_fas_seq_ctrl;
  localparam int unsigned LIMIT = 2;

  logic clk = 1'b0;
  logic rst;
  fas_seq_ctrl_if bus ();

  logic [15:0] re_tab [16];
  logic [15:0] im_tab [16];

  assign bus.bin_re = re_tab[bus.bin_sel];
  assign bus.bin_im = im_tab[bus.bin_sel];

  fas_seq_ctrl #(.FRAME_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected outputs for the current cycle plus event timestamps.
  int          cyc = 0;
  int          scan_c = -100;
  logic [3:0]  m_pending = 4'd0;
  logic [3:0]  m_wptr = 4'd0;
  logic        m_busy = 1'b0;
  logic        e_wr_en = 1'b0, e_start = 1'b0, e_ovr = 1'b0, e_chk_bus = 1'b0;
  logic [3:0]  e_addr = 4'd0, e_freq = 4'd0;
  logic [15:0] e_data = 16'd0;
  int          e_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  // Winner index computed straight from the tables: strict greater keeps the lowest tie.
  function automatic logic [3:0] ref_argmax();
    longint best_mag = -1;
    int     best = 0;
    for (int k = 0; k < 16; k++) begin
      longint r = longint'($signed(re_tab[k]));
      longint i = longint'($signed(im_tab[k]));
      longint m = r * r + i * i;
      if (m > best_mag) begin
        best_mag = m;
        best = k;
      end
    end
    return 4'(best);
  endfunction

  task automatic clear_tab();
    for (int k = 0; k < 16; k++) begin
      re_tab[k] = 16'd0;
      im_tab[k] = 16'd0;
    end
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom % 6)
      0: return 16'h0000;
      1: return 16'h0040;
      2: return 16'hFFC0;
      3: return 16'h0100;
      4: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic cycle(input logic rst_v, input logic v, input logic [15:0] d, input logic fd);
    logic halted, frame_end, nx_start;
    int   dt;
    rst = rst_v;
    bus.fir_valid = v;
    bus.fir_d = d;
    bus.fft_done = fd;
    if (rst_v) begin
      e_wr_en = 1'b0; e_addr = 4'd0; e_data = 16'd0; e_chk_bus = 1'b1;
      e_start = 1'b0; e_freq = 4'd0; e_cnt = 0; e_ovr = 1'b0;
      m_wptr = 4'd0; m_busy = 1'b0; scan_c = -100;
    end else begin
      halted    = (e_cnt == int'(LIMIT));
      frame_end = e_wr_en && (e_addr == 4'd15);
      nx_start  = frame_end && !halted && (!m_busy || fd);
      if (frame_end && m_busy && !fd) e_ovr = 1'b1;
      if (fd) begin
        if (cyc - scan_c >= 18) begin
          scan_c = cyc;
          m_pending = ref_argmax();
        end else begin
          e_ovr = 1'b1;
        end
      end
      m_busy = nx_start ? 1'b1 : (fd ? 1'b0 : m_busy);
      if (v && !halted) begin
        e_wr_en = 1'b1; e_addr = m_wptr; e_data = d; e_chk_bus = 1'b1;
        m_wptr = m_wptr + 4'd1;
      end else begin
        e_wr_en = 1'b0; e_chk_bus = 1'b0;
      end
      e_start = nx_start;
      if (cyc + 1 == scan_c + 17) begin
        e_freq = m_pending;
        if (e_cnt < int'(LIMIT)) e_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    dt = cyc - scan_c;
    check_eq("buf_wr_en", 32'(bus.buf_wr_en), 32'(e_wr_en));
    if (e_chk_bus) begin
      check_eq("buf_wr_addr", 32'(bus.buf_wr_addr), 32'(e_addr));
      check_eq("buf_wr_data", 32'(bus.buf_wr_data), 32'(e_data));
    end
    check_eq("fft_start", 32'(bus.fft_start), 32'(e_start));
    check_eq("bin_sel", 32'(bus.bin_sel), (dt >= 1 && dt <= 16) ? 32'(dt - 1) : 32'd0);
    check_eq("done", 32'(bus.done), 32'(dt == 17));
    check_eq("freq", 32'(bus.freq), 32'(e_freq));
    check_eq("frame_cnt", 32'(bus.frame_cnt), 32'(e_cnt));
    check_eq("overrun", 32'(bus.overrun), 32'(e_ovr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  int n_start;
  int done_due;

  initial begin
    rst = 1'b1;
    bus.fir_valid = 1'b0;
    bus.fir_d = 16'd0;
    bus.fft_done = 1'b0;
    clear_tab();

    cycle(1'b1, 1'b0, 16'd0, 1'b0);
    cycle(1'b1, 1'b1, 16'hBEEF, 1'b1);

    // Frame of ramp samples, then one analysis with a single dominant bin.
    re_tab[1] = 16'h0040;
    re_tab[15] = 16'h0020;
    im_tab[15] = 16'h0020;
    n_start = 0;
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (bus.fft_start) n_start++;
    end
    check_eq("ramp_one_start", 32'(n_start), 32'd1);
    cycle(1'b0, 1'b0, 16'd0, 1'b1);
    idle(18);
    check_eq("dominant_freq", 32'(bus.freq), 32'd1);
    check_eq("dominant_cnt", 32'(bus.frame_cnt), 32'd1);

    // Tie between bins 3 and 9, with a stray fft_done five cycles into the scan.
    clear_tab();
    re_tab[3] = 16'h0100;
    re_tab[9] = 16'h0100;
    cycle(1'b0, 1'b0, 16'd0, 1'b1);
    idle(4);
    cycle(1'b0, 1'b0, 16'd0, 1'b1);
    idle(14);
    check_eq("tie_freq", 32'(bus.freq), 32'd3);
    check_eq("tie_cnt", 32'(bus.frame_cnt), 32'(LIMIT));
    check_eq("stray_done_ovr", 32'(bus.overrun), 32'd1);

    // Halted: writes and launches must stay off until reset.
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 16'($urandom), 1'b0);
    check_eq("halt_wr_en", 32'(bus.buf_wr_en), 32'd0);
    cycle(1'b1, 1'b1, 16'h1234, 1'b1);
    check_eq("rst_cnt", 32'(bus.frame_cnt), 32'd0);

    // Two frames back to back without fft_done: second launch dropped.
    n_start = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b1, 16'($urandom), 1'b0);
      if (bus.fft_start) n_start++;
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (bus.fft_start) n_start++;
    end
    check_eq("busy_one_start", 32'(n_start), 32'd1);
    check_eq("busy_overrun", 32'(bus.overrun), 32'd1);

    // Randomized phases, each starting from reset with fresh bin tables.
    for (int ph = 0; ph < 30; ph++) begin
      for (int k = 0; k < 16; k++) begin
        re_tab[k] = pick_val();
        im_tab[k] = pick_val();
      end
      if (ph % 5 == 0) clear_tab();
      cycle(1'b1, 1'b0, 16'd0, 1'b0);
      done_due = -1;
      for (int i = 0; i < 250; i++) begin
        cycle(($urandom % 400) == 0, ($urandom % 4) != 0, 16'($urandom),
              (cyc == done_due) || (($urandom % 150) == 0));
        if (e_start) done_due = cyc + int'($urandom_range(2, 40));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
